switch_allocator: RTL

//  Per-router switch allocator between the input units and the crossbar. Each input

---
 rtl/switch_allocator.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator
// Description : Per-router switch allocator. Round-robin arbitration per
//               output port, grant held for a whole packet until done.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          i_req,
    input  logic [NUM_PORTS*PORT_W-1:0]   i_target_port,
    input  logic [NUM_PORTS-1:0]          i_packet_done,
    input  logic [NUM_PORTS-1:0]          i_out_free,
    output logic [NUM_PORTS-1:0]          o_grant,
    output logic [NUM_PORTS*PORT_W-1:0]   o_xbar_sel,
    output logic [NUM_PORTS-1:0]          o_xbar_valid,
    output logic                          o_bad_target
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [PORT_W:0] c_num_ports = (PORT_W+1)'(NUM_PORTS);

    logic [NUM_PORTS-1:0]        r_grant;
    logic [NUM_PORTS*PORT_W-1:0] r_xbar_sel;
    logic [NUM_PORTS-1:0]        r_xbar_valid;
    logic                        r_bad_target;

    logic [NUM_PORTS-1:0]        w_busy_next;
    logic [NUM_PORTS*PORT_W-1:0] w_owner_next_bus;
    logic [NUM_PORTS-1:0]        w_grant_next;
    logic [NUM_PORTS*PORT_W-1:0] w_sel_next;
    logic                        w_bad_target;

    generate
        for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
            localparam logic [PORT_W-1:0] c_idx = PORT_W'(o);

            state_t              r_state;
            state_t              w_state_next;
            logic [PORT_W-1:0]   r_owner;
            logic [PORT_W-1:0]   w_owner_next;
            logic [PORT_W-1:0]   r_rr_ptr;
            logic [PORT_W-1:0]   w_rr_ptr_next;
            logic [NUM_PORTS-1:0] w_elig;
            logic                w_found;
            logic [PORT_W-1:0]   w_winner;

            // Inputs already owning an output are kept out of every arbitration.
            always_comb begin
                w_elig = '0;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    w_elig[i] = i_req[i] && !r_grant[i] && i_out_free[o]
                                && (i_target_port[i*PORT_W +: PORT_W] == c_idx);
                end
            end

            always_comb begin
                logic [PORT_W:0] v_sum;
                logic [PORT_W:0] v_idx;
                w_found  = 1'b0;
                w_winner = '0;
                v_sum    = '0;
                v_idx    = '0;
                for (int k = 0; k < NUM_PORTS; k++) begin
                    v_sum = {1'b0, r_rr_ptr} + (PORT_W+1)'(k);
                    v_idx = (v_sum >= c_num_ports) ? (v_sum - c_num_ports) : v_sum;
                    if (!w_found && w_elig[v_idx[PORT_W-1:0]]) begin
                        w_found  = 1'b1;
                        w_winner = v_idx[PORT_W-1:0];
                    end
                end
            end

            always_comb begin
                w_state_next  = r_state;
                w_owner_next  = r_owner;
                w_rr_ptr_next = r_rr_ptr;
                case (r_state)
                    ST_IDLE: begin
                        if (w_found) begin
                            w_state_next  = ST_BUSY;
                            w_owner_next  = w_winner;
                            w_rr_ptr_next = (w_winner == PORT_W'(NUM_PORTS-1)) ? '0
                                                                               : w_winner + 1'b1;
                        end
                    end
                    ST_BUSY: begin
                        if (i_packet_done[r_owner]) begin
                            w_state_next = ST_IDLE;
                        end
                    end
                    default: w_state_next = ST_IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state  <= ST_IDLE;
                    r_owner  <= '0;
                    r_rr_ptr <= '0;
                end else begin
                    r_state  <= w_state_next;
                    r_owner  <= w_owner_next;
                    r_rr_ptr <= w_rr_ptr_next;
                end
            end

            assign w_busy_next[o]                          = (w_state_next == ST_BUSY);
            assign w_owner_next_bus[o*PORT_W +: PORT_W]    = w_owner_next;
        end
    endgenerate

    // Outputs are decoded from next state so they change on the same edge as the FSMs.
    always_comb begin
        w_grant_next = '0;
        w_sel_next   = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (w_busy_next[o]) begin
                w_grant_next[w_owner_next_bus[o*PORT_W +: PORT_W]] = 1'b1;
                w_sel_next[o*PORT_W +: PORT_W] = w_owner_next_bus[o*PORT_W +: PORT_W];
            end
        end
    end

    always_comb begin
        w_bad_target = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (i_req[i] && ({1'b0, i_target_port[i*PORT_W +: PORT_W]} >= c_num_ports)) begin
                w_bad_target = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= '0;
            r_xbar_sel   <= '0;
            r_xbar_valid <= '0;
            r_bad_target <= 1'b0;
        end else begin
            r_grant      <= w_grant_next;
            r_xbar_sel   <= w_sel_next;
            r_xbar_valid <= w_busy_next;
            r_bad_target <= w_bad_target;
        end
    end

    assign o_grant      = r_grant;
    assign o_xbar_sel   = r_xbar_sel;
    assign o_xbar_valid = r_xbar_valid;
    assign o_bad_target = r_bad_target;

endmodule
`default_nettype wire
